iob_pfsm_input_cond: RTL and testbench

// Input conditioning stage that feeds the PFSM input_ports bus. It synchronises async pins,

---
 rtl/iob_pfsm_input_cond_if.sv | 40 ++++
 rtl/iob_pfsm_input_cond.sv | 133 +++++++++++++
 tb/tb_iob_pfsm_input_cond.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_pfsm_input_cond_if.sv
// rtl/iob_pfsm_input_cond_if.sv - conditioning bus between pins/software registers and the PFSM input stage
// slave: the conditioner; master: whatever drives pins and controls and consumes the conditioned bus.
interface iob_pfsm_input_cond_if #(
  parameter int INPUT_W    = 1,
  parameter int DEBOUNCE_W = 8
);
  logic                    enable_i;
  logic [INPUT_W-1:0]      pins_i;
  logic [INPUT_W-1:0]      invert_i;
  logic [2*INPUT_W-1:0]    mode_i;
  logic [DEBOUNCE_W-1:0]   debounce_len_i;
  logic [INPUT_W-1:0]      event_clr_i;
  logic [INPUT_W-1:0]      input_ports_o;
  logic [INPUT_W-1:0]      level_o;
  logic [INPUT_W-1:0]      event_o;

  modport slave (
    input  enable_i,
    input  pins_i,
    input  invert_i,
    input  mode_i,
    input  debounce_len_i,
    input  event_clr_i,
    output input_ports_o,
    output level_o,
    output event_o
  );

  modport master (
    output enable_i,
    output pins_i,
    output invert_i,
    output mode_i,
    output debounce_len_i,
    output event_clr_i,
    input  input_ports_o,
    input  level_o,
    input  event_o
  );
endinterface

// File: rtl/iob_pfsm_input_cond.sv
// rtl/iob_pfsm_input_cond.sv - PFSM input conditioning: sync, debounce, polarity, edge detect, sticky events
// Registered outputs keep the PFSM LUT address glitch-free; a short warm-up suppresses spurious edges.
module iob_pfsm_input_cond #(
  parameter int INPUT_W    = 1,
  parameter int DEBOUNCE_W = 8
) (
  input logic                  clk_i,
  input logic                  cke_i,
  input logic                  rst_i,
  iob_pfsm_input_cond_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WARM   = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] WARM_LAST = 2'd2;

  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_RISE  = 2'b01;
  localparam logic [1:0] MODE_FALL  = 2'b10;

  localparam logic [DEBOUNCE_W-1:0] CNT_ONE = {{(DEBOUNCE_W-1){1'b0}}, 1'b1};
  localparam logic [DEBOUNCE_W-1:0] CNT_MAX = {DEBOUNCE_W{1'b1}};

  logic [1:0]            state_q, state_d;
  logic [1:0]            warm_q, warm_d;
  logic [INPUT_W-1:0]    sync1_q, s_q;
  logic [INPUT_W-1:0]    q_q, q_d;
  logic [DEBOUNCE_W-1:0] cnt_q [INPUT_W];
  logic [DEBOUNCE_W-1:0] cnt_d [INPUT_W];
  logic [INPUT_W-1:0]    c_prev_q, c_prev_d;
  logic [INPUT_W-1:0]    ports_q, ports_d;
  logic [INPUT_W-1:0]    event_q, event_d;

  logic [INPUT_W-1:0]    c, rise, fall, det;
  logic                  run;

  assign c    = q_q ^ bus.invert_i;
  assign rise = c & ~c_prev_q;
  assign fall = ~c & c_prev_q;
  assign run  = (state_q == ST_RUN) && bus.enable_i;

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    if (!bus.enable_i) begin
      state_d = ST_IDLE;
      warm_d  = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WARM;
          warm_d  = 2'd0;
        end
        ST_WARM: begin
          if (warm_q == WARM_LAST) state_d = ST_RUN;
          else                     warm_d  = warm_q + 2'd1;
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    det = '0;
    for (int i = 0; i < INPUT_W; i++) begin
      case (bus.mode_i[2*i +: 2])
        MODE_LEVEL: det[i] = c[i];
        MODE_RISE:  det[i] = rise[i];
        MODE_FALL:  det[i] = fall[i];
        default:    det[i] = rise[i] | fall[i];
      endcase
    end
  end

  // Outside RUN the stable value tracks the synchroniser so RUN starts with no pending mismatch.
  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    for (int i = 0; i < INPUT_W; i++) begin
      if (!run) begin
        q_d[i]   = s_q[i];
        cnt_d[i] = '0;
      end else if (s_q[i] == q_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= bus.debounce_len_i) begin
        q_d[i]   = s_q[i];
        cnt_d[i] = '0;
      end else if (cnt_q[i] != CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // A new edge outranks a same-cycle clear so software never loses an event.
  always_comb begin
    c_prev_d = c;
    ports_d  = run ? det : '0;
    event_d  = run ? ((event_q & ~bus.event_clr_i) | rise | fall) : event_q;
  end

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        state_q  <= ST_IDLE;
        warm_q   <= 2'd0;
        sync1_q  <= '0;
        s_q      <= '0;
        q_q      <= '0;
        cnt_q    <= '{default: '0};
        c_prev_q <= '0;
        ports_q  <= '0;
        event_q  <= '0;
      end else begin
        state_q  <= state_d;
        warm_q   <= warm_d;
        sync1_q  <= bus.pins_i;
        s_q      <= sync1_q;
        q_q      <= q_d;
        cnt_q    <= cnt_d;
        c_prev_q <= c_prev_d;
        ports_q  <= ports_d;
        event_q  <= event_d;
      end
    end
  end

  assign bus.input_ports_o = ports_q;
  assign bus.level_o       = c;
  assign bus.event_o       = event_q;

endmodule

// File: tb/tb_iob_pfsm_input_cond.sv
// tb/tb_iob_pfsm_input_cond.sv - directed and randomized self-checking bench for iob_pfsm_input_cond
module tb_iob_pfsm_input_cond;
  localparam int W  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic cke;
  logic rst;

  iob_pfsm_input_cond_if #(.INPUT_W(W), .DEBOUNCE_W(DW)) bus ();

  iob_pfsm_input_cond #(.INPUT_W(W), .DEBOUNCE_W(DW)) dut (
    .clk_i (clk),
    .cke_i (cke),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: pin delay line, run length of mismatch, enabled-cycle age.
  logic [W-1:0] m_pipe[$];
  logic [W-1:0] m_stable, m_cprev, m_out, m_ev;
  int           m_run[W];
  int           m_age;

  task automatic model_reset();
    m_pipe = {};
    m_pipe.push_back('0);
    m_pipe.push_back('0);
    m_stable = '0;
    m_cprev  = '0;
    m_out    = '0;
    m_ev     = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
    m_age = 0;
  endtask

  task automatic model_edge();
    logic [W-1:0] s, c, rose, fell, d, nst;
    logic [1:0]   md;
    bit           active;
    if (!cke) return;
    if (rst) begin
      model_reset();
      return;
    end
    s      = m_pipe[0];
    c      = m_stable ^ bus.invert_i;
    rose   = c & ~m_cprev;
    fell   = ~c & m_cprev;
    active = bus.enable_i && (m_age >= 4);
    nst    = m_stable;
    for (int i = 0; i < W; i++) begin
      md   = bus.mode_i[2*i +: 2];
      d[i] = (md == 2'b00) ? c[i] : ((md[0] && rose[i]) || (md[1] && fell[i]));
      if (!active) begin
        nst[i]   = s[i];
        m_run[i] = 0;
      end else if (s[i] == m_stable[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i]++;
        if (m_run[i] > int'(bus.debounce_len_i)) begin
          nst[i]   = s[i];
          m_run[i] = 0;
        end
      end
    end
    m_out    = active ? d : '0;
    m_ev     = active ? ((m_ev & ~bus.event_clr_i) | rose | fell) : m_ev;
    m_cprev  = c;
    m_stable = nst;
    void'(m_pipe.pop_front());
    m_pipe.push_back(bus.pins_i);
    m_age = bus.enable_i ? ((m_age < 4) ? m_age + 1 : 4) : 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_ports", 32'(bus.input_ports_o), 32'(m_out));
    check("model_level", 32'(bus.level_o), 32'(m_stable ^ bus.invert_i));
    check("model_event", 32'(bus.event_o), 32'(m_ev));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_events();
    bus.event_clr_i = '1;
    step();
    bus.event_clr_i = '0;
  endtask

  initial begin
    int p0, p1;
    model_reset();
    cke = 1'b1;
    rst = 1'b1;
    bus.enable_i       = 1'b1;
    bus.pins_i         = '0;
    bus.invert_i       = 4'b1010;
    bus.mode_i         = '0;
    bus.debounce_len_i = '0;
    bus.event_clr_i    = '0;
    step();
    check("rst_ports", 32'(bus.input_ports_o), 32'h0);
    check("rst_event", 32'(bus.event_o), 32'h0);
    check("rst_level_is_invert", 32'(bus.level_o), 32'b1010);

    // reset release with pins high: warm-up holds the bus at 0
    bus.invert_i = '0;
    bus.pins_i   = '1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("t1_warmup", 32'(bus.input_ports_o[0]), 32'(k >= 4));
    end
    check("t1_no_event", 32'(bus.event_o), 32'h0);

    // rise mode, len=4: single pulse 7 edges after the first sampling edge
    bus.pins_i         = '0;
    bus.mode_i         = 8'b0101_0101;
    bus.debounce_len_i = 8'd4;
    steps(12);
    clear_events();
    bus.pins_i = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      step();
      check("t2_pulse", 32'(bus.input_ports_o[0]), 32'(k == 7));
    end
    check("t2_event", 32'(bus.event_o[0]), 32'h1);

    // short glitch filtered; 5-cycle pulse passes (bit0 rise, bit1 fall)
    bus.pins_i = '0;
    bus.mode_i = 8'b0000_1001;
    steps(12);
    clear_events();
    p0 = 0; p1 = 0;
    bus.pins_i = 4'b0011;
    for (int k = 0; k < 18; k++) begin
      if (k == 3) bus.pins_i = '0;
      step();
      p0 += int'(bus.input_ports_o[0]);
      p1 += int'(bus.input_ports_o[1]);
    end
    check("t3_glitch_rise", 32'(p0), 32'd0);
    check("t3_glitch_fall", 32'(p1), 32'd0);
    check("t3_glitch_event", 32'(bus.event_o[1:0]), 32'h0);
    p0 = 0; p1 = 0;
    bus.pins_i = 4'b0011;
    for (int k = 0; k < 20; k++) begin
      if (k == 5) bus.pins_i = '0;
      step();
      p0 += int'(bus.input_ports_o[0]);
      p1 += int'(bus.input_ports_o[1]);
    end
    check("t3_pulse_rise", 32'(p0), 32'd1);
    check("t3_pulse_fall", 32'(p1), 32'd1);

    // polarity change done while disabled; any-edge then fall with invert
    bus.enable_i = 1'b0;
    bus.invert_i = 4'b0001;
    bus.mode_i   = 8'b0000_0011;
    steps(2);
    bus.enable_i = 1'b1;
    steps(10);
    check("t4_no_spurious", 32'(bus.input_ports_o[0]), 32'h0);
    clear_events();
    p0 = 0;
    bus.pins_i = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) bus.pins_i = '0;
      step();
      p0 += int'(bus.input_ports_o[0]);
    end
    check("t4_any_pulses", 32'(p0), 32'd2);
    bus.mode_i = 8'b0000_0010;
    p0 = 0;
    bus.pins_i = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      step();
      p0 += int'(bus.input_ports_o[0]);
    end
    check("t4_fall_inverted", 32'(p0), 32'd1);

    // clock-enable freeze in the middle of a debounce count
    bus.enable_i = 1'b0;
    bus.invert_i = '0;
    bus.mode_i   = '0;
    bus.pins_i   = '0;
    steps(2);
    bus.enable_i = 1'b1;
    steps(12);
    bus.pins_i = 4'b0001;
    steps(4);
    cke = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.pins_i = 4'($urandom);
      step();
      check("t5_frozen", 32'(bus.input_ports_o), 32'h0);
    end
    bus.pins_i = 4'b0001;
    cke = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("t5_resume", 32'(bus.input_ports_o[0]), 32'(k >= 3));
    end

    // set beats clear in the same cycle
    bus.debounce_len_i = '0;
    bus.mode_i = 8'b0000_0001;
    bus.pins_i = '0;
    steps(8);
    clear_events();
    check("t6_cleared", 32'(bus.event_o), 32'h0);
    bus.pins_i = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      bus.event_clr_i = (k == 3) ? 4'b0001 : 4'b0000;
      step();
      if (k == 3) check("t6_set_wins", 32'(bus.event_o[0]), 32'h1);
    end
    bus.event_clr_i = 4'b0001;
    step();
    bus.event_clr_i = '0;
    check("t6_clear", 32'(bus.event_o[0]), 32'h0);

    // reset in the middle of a count
    bus.debounce_len_i = 8'd4;
    bus.mode_i = '0;
    bus.pins_i = 4'b0001;
    steps(8);
    bus.pins_i = '0;
    steps(3);
    rst = 1'b1;
    step();
    check("t6_rst_ports", 32'(bus.input_ports_o), 32'h0);
    check("t6_rst_event", 32'(bus.event_o), 32'h0);
    check("t6_rst_level", 32'(bus.level_o), 32'h0);
    rst = 1'b0;

    // randomized traffic against the reference
    for (int n = 0; n < 3000; n++) begin
      cke = ($urandom_range(9) != 0);
      rst = ($urandom_range(199) == 0);
      if ($urandom_range(99) == 0) bus.enable_i = ~bus.enable_i;
      for (int i = 0; i < W; i++)
        if ($urandom_range(5) == 0) bus.pins_i[i] = ~bus.pins_i[i];
      if ($urandom_range(149) == 0) bus.invert_i = 4'($urandom);
      if ($urandom_range(99) == 0) bus.mode_i = 8'($urandom);
      if ($urandom_range(79) == 0) bus.debounce_len_i = 8'($urandom_range(5));
      bus.event_clr_i = ($urandom_range(7) == 0) ? 4'($urandom) : 4'b0000;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
